// File: rtl/sequenciador_jogada_if.sv
// Board RAM bus between the move sequencer (master) and the 81-cell board memory (slave).
interface sequenciador_jogada_if;
  logic [6:0] mem_addr;
  logic       mem_we;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata;

  modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/sequenciador_jogada.sv
// Sequences one move on the 9x9 board RAM: check target cell, write symbol, reload micro board, evaluate.
// Optional move counter on db_jogadas enabled by defining CONTA_JOGADAS_EN.
module sequenciador_jogada #(
  parameter logic [1:0] SIMB_X = 2'b01,
  parameter logic [1:0] SIMB_O = 2'b10
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         iniciar_jogada,
  input  logic [3:0]                   macro_pos,
  input  logic [3:0]                   micro_pos,
  input  logic                         jogador,
  sequenciador_jogada_if.master        mem,
  output logic                         ocupado,
  output logic                         pronto,
  output logic                         jogada_invalida,
  output logic                         venceu_micro,
  output logic                         micro_cheio,
  output logic [3:0]                   db_estado,
  output logic [6:0]                   db_jogadas
);

  localparam int unsigned ULTIMA_CELULA = 8;
  localparam int unsigned FIM_CARGA     = 9;

  typedef enum logic [3:0] {
    OCIOSO    = 4'h0,
    LE_CELULA = 4'h1,
    VERIFICA  = 4'h2,
    ESCREVE   = 4'h3,
    CARREGA   = 4'h4,
    AVALIA    = 4'h5,
    FIM       = 4'hF
  } estado_t;

  estado_t          estado;
  logic [3:0]       macro_q;
  logic [3:0]       micro_q;
  logic             jogador_q;
  logic [3:0]       k;
  logic [8:0][1:0]  celula_q;
  logic [1:0]       simbolo;
  logic             vitoria_c;
  logic             cheio_c;

  function automatic logic [6:0] endereco(input logic [3:0] m, input logic [3:0] c);
    return 7'(m) * 7'd9 + 7'(c);
  endfunction

  function automatic logic tres(input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] c, input logic [1:0] s);
    return (a == s) && (b == s) && (c == s);
  endfunction

  assign simbolo   = jogador_q ? SIMB_O : SIMB_X;
  assign db_estado = estado;

  // Line and fullness evaluation over the reloaded micro board
  always_comb begin
    vitoria_c = tres(celula_q[0], celula_q[1], celula_q[2], simbolo) ||
                tres(celula_q[3], celula_q[4], celula_q[5], simbolo) ||
                tres(celula_q[6], celula_q[7], celula_q[8], simbolo) ||
                tres(celula_q[0], celula_q[3], celula_q[6], simbolo) ||
                tres(celula_q[1], celula_q[4], celula_q[7], simbolo) ||
                tres(celula_q[2], celula_q[5], celula_q[8], simbolo) ||
                tres(celula_q[0], celula_q[4], celula_q[8], simbolo) ||
                tres(celula_q[2], celula_q[4], celula_q[6], simbolo);
    cheio_c   = (celula_q[0] != 2'b00) && (celula_q[1] != 2'b00) && (celula_q[2] != 2'b00) &&
                (celula_q[3] != 2'b00) && (celula_q[4] != 2'b00) && (celula_q[5] != 2'b00) &&
                (celula_q[6] != 2'b00) && (celula_q[7] != 2'b00) && (celula_q[8] != 2'b00);
  end

  // Outputs are set on the transition into the state in which they must be visible
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado          <= OCIOSO;
      macro_q         <= '0;
      micro_q         <= '0;
      jogador_q       <= 1'b0;
      k               <= '0;
      celula_q        <= '0;
      mem.mem_addr    <= '0;
      mem.mem_we      <= 1'b0;
      mem.mem_wdata   <= '0;
      ocupado         <= 1'b0;
      pronto          <= 1'b0;
      jogada_invalida <= 1'b0;
      venceu_micro    <= 1'b0;
      micro_cheio     <= 1'b0;
    end else begin
      mem.mem_addr  <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_wdata <= '0;
      pronto        <= 1'b0;
      ocupado       <= 1'b1;
      case (estado)
        OCIOSO: begin
          ocupado <= 1'b0;
          if (iniciar_jogada) begin
            macro_q      <= macro_pos;
            micro_q      <= micro_pos;
            jogador_q    <= jogador;
            venceu_micro <= 1'b0;
            micro_cheio  <= 1'b0;
            ocupado      <= 1'b1;
            if (macro_pos > 4'(ULTIMA_CELULA) || micro_pos > 4'(ULTIMA_CELULA)) begin
              jogada_invalida <= 1'b1;
              pronto          <= 1'b1;
              estado          <= FIM;
            end else begin
              jogada_invalida <= 1'b0;
              mem.mem_addr    <= endereco(macro_pos, micro_pos);
              estado          <= LE_CELULA;
            end
          end
        end
        LE_CELULA: estado <= VERIFICA;
        VERIFICA: begin
          if (mem.mem_rdata != 2'b00) begin
            jogada_invalida <= 1'b1;
            pronto          <= 1'b1;
            estado          <= FIM;
          end else begin
            mem.mem_we    <= 1'b1;
            mem.mem_addr  <= endereco(macro_q, micro_q);
            mem.mem_wdata <= simbolo;
            estado        <= ESCREVE;
          end
        end
        ESCREVE: begin
          k            <= '0;
          mem.mem_addr <= endereco(macro_q, 4'd0);
          estado       <= CARREGA;
        end
        CARREGA: begin
          // Read data lags the address by one cycle, so slot k holds cell k-1
          if (k != 4'd0) celula_q[k - 4'd1] <= mem.mem_rdata;
          if (k == 4'(FIM_CARGA)) begin
            estado <= AVALIA;
          end else begin
            k <= k + 4'd1;
            if (k != 4'(ULTIMA_CELULA)) mem.mem_addr <= endereco(macro_q, k + 4'd1);
          end
        end
        AVALIA: begin
          venceu_micro <= vitoria_c;
          micro_cheio  <= cheio_c;
          pronto       <= 1'b1;
          estado       <= FIM;
        end
        FIM: begin
          ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
        default: begin
          ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
      endcase
    end
  end

`ifdef CONTA_JOGADAS_EN
  localparam int unsigned TOTAL_CELULAS = 81;
  logic [6:0] jogadas_q;

  // Counts accepted writes, saturating at a full board
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jogadas_q <= '0;
    end else if (estado == ESCREVE && jogadas_q < 7'(TOTAL_CELULAS)) begin
      jogadas_q <= jogadas_q + 7'd1;
    end
  end
  assign db_jogadas = jogadas_q;
`else
  assign db_jogadas = '0;
`endif

endmodule

// File: tb/tb_sequenciador_jogada.sv
// Self-checking bench for sequenciador_jogada with a behavioural board RAM and move model.
module tb_sequenciador_jogada;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar_jogada;
  logic [3:0] macro_pos;
  logic [3:0] micro_pos;
  logic       jogador;
  logic       ocupado, pronto, jogada_invalida, venceu_micro, micro_cheio;
  logic [3:0] db_estado;
  logic [6:0] db_jogadas;

  sequenciador_jogada_if bus();

  sequenciador_jogada dut (
    .clock(clock), .reset(reset), .iniciar_jogada(iniciar_jogada),
    .macro_pos(macro_pos), .micro_pos(micro_pos), .jogador(jogador),
    .mem(bus), .ocupado(ocupado), .pronto(pronto),
    .jogada_invalida(jogada_invalida), .venceu_micro(venceu_micro),
    .micro_cheio(micro_cheio), .db_estado(db_estado), .db_jogadas(db_jogadas)
  );

  always #5 clock = ~clock;

  logic [1:0] ram [81];
  int ntests = 0;
  int nfail  = 0;
  int exp_jog = 0;
  int linhas [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  // Board RAM with one-cycle read latency
  always @(posedge clock) begin
    int a;
    a = int'(bus.mem_addr);
    bus.mem_rdata <= (a < 81) ? ram[a] : 2'b00;
    if (bus.mem_we && a < 81) ram[a] = bus.mem_wdata;
  end

  function automatic int exp_db();
`ifdef CONTA_JOGADAS_EN
    return (exp_jog > 81) ? 81 : exp_jog;
`else
    return 0;
`endif
  endfunction

  // Expected outcome of a move computed from the rules over the current board contents
  function automatic void model(input int mac, input int mic, input bit jog,
                                output bit inv, output bit win, output bit full,
                                output int cyc, output int addr, output int data);
    int b [9];
    int s;
    s = jog ? 2 : 1;
    inv = 0; win = 0; full = 0; addr = -1; data = 0;
    if (mac > 8 || mic > 8) begin inv = 1; cyc = 1; return; end
    if (ram[mac*9 + mic] != 2'b00) begin inv = 1; cyc = 3; return; end
    addr = mac*9 + mic; data = s; cyc = 15;
    for (int i = 0; i < 9; i++) b[i] = int'(ram[mac*9 + i]);
    b[mic] = s;
    for (int l = 0; l < 8; l++)
      if (b[linhas[l][0]] == s && b[linhas[l][1]] == s && b[linhas[l][2]] == s) win = 1;
    full = 1;
    for (int i = 0; i < 9; i++) if (b[i] == 0) full = 0;
  endfunction

  task automatic clear_ram();
    for (int i = 0; i < 81; i++) ram[i] = 2'b00;
  endtask

  // Issues one start pulse; reports the cycle of pronto (start edge = edge 0), writes seen, addr in FIM
  task automatic do_move(input logic [3:0] mac, input logic [3:0] mic, input logic jog, input bit spam,
                         output int cyc, output int n_we, output int w_addr, output int w_data,
                         output int addr_fim);
    cyc = -1; n_we = 0; w_addr = -1; w_data = -1; addr_fim = -1;
    @(negedge clock);
    iniciar_jogada = 1'b1; macro_pos = mac; micro_pos = mic; jogador = jog;
    @(posedge clock); #1;
    iniciar_jogada = 1'b0;
    if (spam) begin
      iniciar_jogada = 1'b1; macro_pos = 4'd0; micro_pos = 4'd0; jogador = ~jog;
    end
    for (int e = 0; e < 40; e++) begin
      if (bus.mem_we) begin n_we++; w_addr = int'(bus.mem_addr); w_data = int'(bus.mem_wdata); end
      if (pronto) begin cyc = e + 1; addr_fim = int'(bus.mem_addr); break; end
      @(posedge clock); #1;
    end
    iniciar_jogada = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; iniciar_jogada = 1'b0; macro_pos = '0; micro_pos = '0; jogador = 1'b0;
    clear_ram();
    repeat (2) @(posedge clock);
    #1;
    ntests++; if (db_estado !== 4'h0) begin nfail++; $display("FAIL reset_estado got %0h exp 0", db_estado); end
    ntests++; if ({ocupado, pronto, jogada_invalida, venceu_micro, micro_cheio} !== 5'b0) begin
      nfail++; $display("FAIL reset_flags got %b exp 00000", {ocupado, pronto, jogada_invalida, venceu_micro, micro_cheio}); end
    ntests++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 7'd0 || bus.mem_wdata !== 2'd0) begin
      nfail++; $display("FAIL reset_bus got we=%b addr=%0d wd=%0d exp 0", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    ntests++; if (db_jogadas !== 7'd0) begin nfail++; $display("FAIL reset_jogadas got %0d exp 0", db_jogadas); end
    @(negedge clock);
    reset = 1'b1;
    exp_jog = 0;
  endtask

  task automatic test_valid_empty();
    int cyc, nwe, wa, wd, af;
    clear_ram();
    do_move(4'd4, 4'd0, 1'b0, 1'b0, cyc, nwe, wa, wd, af);
    exp_jog++;
    ntests++; if (cyc != 15) begin nfail++; $display("FAIL empty_latency got %0d exp 15", cyc); end
    ntests++; if (nwe != 1 || wa != 36 || wd != 1) begin
      nfail++; $display("FAIL empty_write got n=%0d addr=%0d data=%0d exp n=1 addr=36 data=1", nwe, wa, wd); end
    ntests++; if ({jogada_invalida, venceu_micro, micro_cheio} !== 3'b000) begin
      nfail++; $display("FAIL empty_verdicts got %b exp 000", {jogada_invalida, venceu_micro, micro_cheio}); end
    ntests++; if (af != 0) begin nfail++; $display("FAIL empty_addr_fim got %0d exp 0", af); end
    ntests++; if (ocupado !== 1'b0 || db_estado !== 4'h0) begin
      nfail++; $display("FAIL empty_idle got ocupado=%b estado=%0h exp 0/0", ocupado, db_estado); end
  endtask

  task automatic test_win();
    int cyc, nwe, wa, wd, af;
    clear_ram();
    ram[36] = 2'b01; ram[37] = 2'b01;
    do_move(4'd4, 4'd2, 1'b0, 1'b0, cyc, nwe, wa, wd, af);
    exp_jog++;
    ntests++; if (nwe != 1 || wa != 38 || wd != 1) begin
      nfail++; $display("FAIL win_write got n=%0d addr=%0d data=%0d exp n=1 addr=38 data=1", nwe, wa, wd); end
    ntests++; if ({jogada_invalida, venceu_micro, micro_cheio} !== 3'b010) begin
      nfail++; $display("FAIL win_verdicts got %b exp 010", {jogada_invalida, venceu_micro, micro_cheio}); end
  endtask

  task automatic test_occupied();
    int cyc, nwe, wa, wd, af;
    clear_ram();
    ram[10] = 2'b10;
    do_move(4'd1, 4'd1, 1'b0, 1'b0, cyc, nwe, wa, wd, af);
    ntests++; if (cyc != 3) begin nfail++; $display("FAIL occ_latency got %0d exp 3", cyc); end
    ntests++; if (nwe != 0) begin nfail++; $display("FAIL occ_no_write got %0d writes exp 0", nwe); end
    ntests++; if ({jogada_invalida, venceu_micro, micro_cheio} !== 3'b100) begin
      nfail++; $display("FAIL occ_verdicts got %b exp 100", {jogada_invalida, venceu_micro, micro_cheio}); end
  endtask

  task automatic test_full_and_range();
    int cyc, nwe, wa, wd, af;
    int pat [9] = '{1, 2, 1, 2, 0, 1, 2, 1, 2};
    clear_ram();
    for (int i = 0; i < 9; i++) ram[72 + i] = 2'(pat[i]);
    do_move(4'd8, 4'd4, 1'b1, 1'b0, cyc, nwe, wa, wd, af);
    exp_jog++;
    ntests++; if (nwe != 1 || wa != 76 || wd != 2) begin
      nfail++; $display("FAIL full_write got n=%0d addr=%0d data=%0d exp n=1 addr=76 data=2", nwe, wa, wd); end
    ntests++; if ({jogada_invalida, venceu_micro, micro_cheio} !== 3'b001) begin
      nfail++; $display("FAIL full_verdicts got %b exp 001", {jogada_invalida, venceu_micro, micro_cheio}); end
    do_move(4'd0, 4'd9, 1'b0, 1'b0, cyc, nwe, wa, wd, af);
    ntests++; if (cyc != 1) begin nfail++; $display("FAIL range_latency got %0d exp 1", cyc); end
    ntests++; if (nwe != 0 || jogada_invalida !== 1'b1) begin
      nfail++; $display("FAIL range_verdict got writes=%0d inv=%b exp 0/1", nwe, jogada_invalida); end
  endtask

  task automatic test_reset_mid();
    int cyc, nwe, wa, wd, af;
    clear_ram();
    @(negedge clock);
    iniciar_jogada = 1'b1; macro_pos = 4'd2; micro_pos = 4'd5; jogador = 1'b1;
    @(posedge clock); #1;
    iniciar_jogada = 1'b0;
    repeat (6) @(posedge clock);
    #2;
    ntests++; if (ocupado !== 1'b1 || db_estado !== 4'h4) begin
      nfail++; $display("FAIL mid_in_carrega got ocupado=%b estado=%0h exp 1/4", ocupado, db_estado); end
    reset = 1'b0;
    exp_jog = 0;
    #1;
    ntests++; if ({ocupado, pronto, jogada_invalida, venceu_micro, micro_cheio} !== 5'b0 ||
                  db_estado !== 4'h0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 7'd0) begin
      nfail++; $display("FAIL mid_reset got flags=%b estado=%0h we=%b addr=%0d exp all 0",
        {ocupado, pronto, jogada_invalida, venceu_micro, micro_cheio}, db_estado, bus.mem_we, bus.mem_addr); end
    ntests++; if (ram[23] !== 2'b10) begin nfail++; $display("FAIL mid_prior_write got %0d exp 2", ram[23]); end
    ntests++; if (db_jogadas !== 7'd0) begin nfail++; $display("FAIL mid_jogadas got %0d exp 0", db_jogadas); end
    @(negedge clock);
    reset = 1'b1;
    do_move(4'd2, 4'd6, 1'b0, 1'b0, cyc, nwe, wa, wd, af);
    exp_jog++;
    ntests++; if (cyc != 15 || nwe != 1 || wa != 24 || wd != 1) begin
      nfail++; $display("FAIL mid_after got cyc=%0d n=%0d addr=%0d data=%0d exp 15/1/24/1", cyc, nwe, wa, wd); end
  endtask

  task automatic test_busy_ignore();
    int cyc, nwe, wa, wd, af;
    clear_ram();
    do_move(4'd7, 4'd8, 1'b1, 1'b1, cyc, nwe, wa, wd, af);
    exp_jog++;
    ntests++; if (cyc != 15 || nwe != 1 || wa != 71 || wd != 2) begin
      nfail++; $display("FAIL busy_ignore got cyc=%0d n=%0d addr=%0d data=%0d exp 15/1/71/2", cyc, nwe, wa, wd); end
    ntests++; if (ram[0] !== 2'b00) begin nfail++; $display("FAIL busy_stray_write got %0d exp 0", ram[0]); end
  endtask

  task automatic test_counter();
    int cyc, nwe, wa, wd, af;
    @(negedge clock); reset = 1'b0; exp_jog = 0;
    @(negedge clock); reset = 1'b1;
    clear_ram();
    for (int i = 0; i < 3; i++) begin
      do_move(4'd3, 4'(i), 1'b0, 1'b0, cyc, nwe, wa, wd, af);
      exp_jog++;
    end
    do_move(4'd9, 4'd0, 1'b0, 1'b0, cyc, nwe, wa, wd, af);
    ntests++; if (int'(db_jogadas) != exp_db()) begin
      nfail++; $display("FAIL counter got %0d exp %0d", db_jogadas, exp_db()); end
  endtask

  task automatic test_random();
    int cyc, nwe, wa, wd, af, e_cyc, e_addr, e_data;
    bit e_inv, e_win, e_full;
    logic [3:0] mac, mic;
    logic jog;
    for (int n = 0; n < 30; n++) begin
      mac = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      mic = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      jog = 1'($urandom_range(0, 1));
      if (mac <= 4'd8)
        for (int i = 0; i < 9; i++) begin
          int r;
          r = int'($urandom_range(0, 4));
          ram[int'(mac)*9 + i] = (r >= 2) ? 2'b00 : 2'(r + 1);
        end
      model(int'(mac), int'(mic), jog, e_inv, e_win, e_full, e_cyc, e_addr, e_data);
      do_move(mac, mic, jog, 1'b0, cyc, nwe, wa, wd, af);
      if (!e_inv) exp_jog++;
      ntests++; if (cyc != e_cyc) begin nfail++; $display("FAIL rnd%0d_latency got %0d exp %0d", n, cyc, e_cyc); end
      ntests++; if (nwe != (e_inv ? 0 : 1) || (!e_inv && (wa != e_addr || wd != e_data))) begin
        nfail++; $display("FAIL rnd%0d_write got n=%0d addr=%0d data=%0d exp addr=%0d data=%0d", n, nwe, wa, wd, e_addr, e_data); end
      ntests++; if ({jogada_invalida, venceu_micro, micro_cheio} !== {e_inv, e_win, e_full}) begin
        nfail++; $display("FAIL rnd%0d_verdicts got %b exp %b", n, {jogada_invalida, venceu_micro, micro_cheio}, {e_inv, e_win, e_full}); end
      ntests++; if (int'(db_jogadas) != exp_db()) begin
        nfail++; $display("FAIL rnd%0d_jogadas got %0d exp %0d", n, db_jogadas, exp_db()); end
    end
  endtask

  initial begin
    test_reset();
    test_valid_empty();
    test_win();
    test_occupied();
    test_full_and_range();
    test_reset_mid();
    test_busy_ignore();
    test_counter();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
